// File: rtl/dac_spi_master.sv
// Multi-channel SPI write master for serial DACs: SYNC-low framing, MSB first, SCLK idles high.
// Define DAC_SPI_READBACK_EN to add MISO capture (spi_miso, rd_data, rd_valid).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a command; bad channel pulses err and stays here
// S_SETUP | SYNC low, SCLK high, MSB driven, CLKDIV cycles
// S_SHIFT | DWIDTH bits, each CLKDIV low then CLKDIV high
// S_GAP   | all SYNC high for CS_GAP cycles, done on the last one
module dac_spi_master #(
  parameter int DWIDTH = 24,
  parameter int NCH    = 2,
  parameter int CLKDIV = 16,
  parameter int CS_GAP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [$clog2(NCH)-1:0] cmd_ch,
  input  logic [DWIDTH-1:0]      cmd_word,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  output logic [NCH-1:0]         spi_sync_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err
`ifdef DAC_SPI_READBACK_EN
  ,
  input  logic                   spi_miso,
  output logic [DWIDTH-1:0]      rd_data,
  output logic                   rd_valid
`endif
);

  localparam int CW = $clog2(NCH);
  localparam int HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(DWIDTH);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [HW-1:0] HALF_TC = HW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_TC  = BW'(DWIDTH - 1);
  localparam logic [GW-1:0] GAP_TC  = GW'(CS_GAP - 1);
  localparam logic [CW:0]   NCH_L   = (CW + 1)'(NCH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        r_state;
  logic [HW-1:0]     r_half;
  logic [BW-1:0]     r_bit;
  logic [GW-1:0]     r_gap;
  logic              r_phase;
  logic [DWIDTH-1:0] r_shreg;
  logic [CW-1:0]     r_ch;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_sclk;
  logic              r_mosi;
  logic [NCH-1:0]    r_sync_n;

  logic              w_accept;
  logic              w_ch_ok;
  logic              w_active;
  logic [NCH-1:0]    w_sel;

  assign w_ch_ok  = ({1'b0, cmd_ch} < NCH_L);
  assign w_accept = (r_state == S_IDLE) && cmd_valid && r_ready;
  assign w_active = (r_state == S_SETUP) || (r_state == S_SHIFT);
  assign w_sel    = {{(NCH-1){1'b0}}, 1'b1} << r_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_half  <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_phase <= 1'b0;
      r_shreg <= '0;
      r_ch    <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_ch_ok) begin
              r_ch    <= cmd_ch;
              r_shreg <= cmd_word;
              r_half  <= HALF_TC;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_SETUP;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (r_half == '0) begin
            r_half  <= HALF_TC;
            r_phase <= 1'b0;
            r_bit   <= BIT_TC;
            r_state <= S_SHIFT;
          end else begin
            r_half <= r_half - 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_half != '0) begin
            r_half <= r_half - 1'b1;
          end else if (!r_phase) begin
            // Rising SCLK: present the next bit (zeros fill in after the LSB).
            r_half  <= HALF_TC;
            r_phase <= 1'b1;
            r_shreg <= {r_shreg[DWIDTH-2:0], 1'b0};
          end else if (r_bit == '0) begin
            r_phase <= 1'b0;
            r_gap   <= GAP_TC;
            r_state <= S_GAP;
          end else begin
            r_half  <= HALF_TC;
            r_phase <= 1'b0;
            r_bit   <= r_bit - 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pin registers follow the state one cycle later, so SYNC spans SETUP+SHIFT exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk   <= 1'b1;
      r_mosi   <= 1'b0;
      r_sync_n <= '1;
    end else begin
      r_sclk   <= !((r_state == S_SHIFT) && !r_phase);
      r_mosi   <= w_active && r_shreg[DWIDTH-1];
      r_sync_n <= w_active ? ~w_sel : '1;
    end
  end

  assign cmd_ready  = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign spi_sclk   = r_sclk;
  assign spi_mosi   = r_mosi;
  assign spi_sync_n = r_sync_n;

`ifdef DAC_SPI_READBACK_EN
  logic [DWIDTH-1:0] r_rd_sh;
  logic [DWIDTH-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              w_fall;

  // First low-phase cycle: the pin SCLK falls on this edge.
  assign w_fall = (r_state == S_SHIFT) && !r_phase && (r_half == HALF_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sh    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_fall) begin
        r_rd_sh <= {r_rd_sh[DWIDTH-2:0], spi_miso};
      end
      if ((r_state == S_GAP) && (r_gap == '0)) begin
        r_rd_data  <= r_rd_sh;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_dac_spi_master.sv
// Self-checking bench for dac_spi_master: scoreboard of expected frames vs a pin-level SPI monitor.
// Readback checks are compiled in when DAC_SPI_READBACK_EN is defined.
module tb_dac_spi_master;

  localparam int DW = 24;
  localparam int CD = 2;
  localparam int CG = 4;
  localparam int SYNC_LOW = CD * (1 + 2 * DW);
  localparam int LATENCY  = 1 + CD * (1 + 2 * DW) + CG;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [0:0]    cmd_ch = '0;
  logic [DW-1:0] cmd_word = '0;
  logic          cmd_ready, spi_sclk, spi_mosi, busy, done, err;
  logic [1:0]    spi_sync_n;

  logic          valid3 = 1'b0;
  logic [1:0]    ch3 = '0;
  logic [DW-1:0] word3 = '0;
  logic          ready3, sclk3, mosi3, busy3, done3, err3;
  logic [2:0]    sync3;

`ifdef DAC_SPI_READBACK_EN
  logic          spi_miso = 1'b0;
  logic          miso3 = 1'b0;
  logic [DW-1:0] rd_data, rd_data3, miso_pat = '0, rd_seen = '0;
  logic          rd_valid, rd_valid3;
  int            rd_cnt = 0;
  bit            rd_coinc_bad = 0;
`endif

  always #5 clk = ~clk;

  dac_spi_master #(.DWIDTH(DW), .NCH(2), .CLKDIV(CD), .CS_GAP(CG)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_word(cmd_word), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_sync_n(spi_sync_n), .busy(busy), .done(done), .err(err)
`ifdef DAC_SPI_READBACK_EN
    , .spi_miso(spi_miso), .rd_data(rd_data), .rd_valid(rd_valid)
`endif
  );

  dac_spi_master #(.DWIDTH(DW), .NCH(3), .CLKDIV(CD), .CS_GAP(CG)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid3), .cmd_ready(ready3),
    .cmd_ch(ch3), .cmd_word(word3), .spi_sclk(sclk3), .spi_mosi(mosi3),
    .spi_sync_n(sync3), .busy(busy3), .done(done3), .err(err3)
`ifdef DAC_SPI_READBACK_EN
    , .spi_miso(miso3), .rd_data(rd_data3), .rd_valid(rd_valid3)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard entries are {channel, word}.
  logic [DW:0] sb[$];

  bit            in_frame = 0;
  bit            gap_run = 0;
  bit            onehot_bad = 0;
  int            low_cnt = 0, falls = 0, gap_cnt = 0, last_gap = -1;
  int            done_cnt = 0, err_cnt = 0, err3_cnt = 0, done3_cnt = 0, sync3_low = 0;
  logic [DW-1:0] cap = '0;
  logic [0:0]    fch = '0;
  logic          prev_sclk = 1'b1;
  logic [DW:0]   exp_e;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (err3) err3_cnt++;
    if (done3) done3_cnt++;
    if (sync3 != 3'b111) sync3_low++;
`ifdef DAC_SPI_READBACK_EN
    if (rd_valid) begin
      rd_cnt++;
      rd_seen = rd_data;
    end
    if (rd_valid !== done) rd_coinc_bad = 1;
`endif
    if (!rst_n) begin
      in_frame = 0;
      gap_run  = 0;
    end else if (spi_sync_n != 2'b11) begin
      if (!in_frame) begin
        in_frame   = 1;
        low_cnt    = 0;
        falls      = 0;
        cap        = '0;
        onehot_bad = 0;
        fch        = spi_sync_n[0] ? 1'b1 : 1'b0;
        if (gap_run) last_gap = gap_cnt;
        gap_run = 0;
      end
      if (spi_sync_n != ~(2'b01 << fch)) onehot_bad = 1;
      low_cnt++;
      if (prev_sclk && !spi_sclk) begin
        cap = {cap[DW-2:0], spi_mosi};
        falls++;
      end
    end else if (in_frame) begin
      in_frame = 0;
      gap_run  = 1;
      gap_cnt  = 1;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_frame: got word %h on ch %0d, required no frame", cap, fch);
      end else begin
        exp_e = sb.pop_front();
        if (cap !== exp_e[DW-1:0]) begin
          miscompares++;
          $display("FAIL sb_word: got %h, required %h", cap, exp_e[DW-1:0]);
        end
        vectors++;
        if (fch !== exp_e[DW:DW]) begin
          miscompares++;
          $display("FAIL sb_channel: got %0d, required %0d", fch, exp_e[DW]);
        end
        vectors++;
        if (falls != DW) begin
          miscompares++;
          $display("FAIL sb_fall_count: got %0d, required %0d", falls, DW);
        end
        vectors++;
        if (low_cnt != SYNC_LOW) begin
          miscompares++;
          $display("FAIL sb_sync_low_cycles: got %0d, required %0d", low_cnt, SYNC_LOW);
        end
        vectors++;
        if (onehot_bad) begin
          miscompares++;
          $display("FAIL sb_sync_onehot: got a non-one-hot SYNC pattern, required exactly one low");
        end
      end
    end else if (gap_run) begin
      gap_cnt++;
    end
    prev_sclk = spi_sclk;
`ifdef DAC_SPI_READBACK_EN
    spi_miso = (falls < DW) ? miso_pat[DW-1-falls] : 1'b0;
`endif
  end

  task automatic send(input logic ch, input logic [DW-1:0] w);
    int n;
    n = 0;
    cmd_ch    = ch;
    cmd_word  = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: cmd_ready got 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 1;
    while (!cmd_ready && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 1000) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: cmd_ready got 0, required 1 within 1000 cycles");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (spi_sync_n !== 2'b11 || spi_sclk !== 1'b1 || spi_mosi !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pins: got sync=%b sclk=%b mosi=%b, required 11 1 0", spi_sync_n, spi_sclk, spi_mosi);
    end
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: got ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if (spi_sync_n !== 2'b11) begin
      miscompares++;
      $display("FAIL idle_sync: got %b, required 11", spi_sync_n);
    end
    vectors++;
    if (spi_sclk !== 1'b1 || spi_mosi !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_sclk_mosi: got %b %b, required 1 0", spi_sclk, spi_mosi);
    end
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready: got ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    vectors++;
    if (done_cnt != 0 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL idle_pulses: got done=%0d err=%0d, required 0 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_single_frame;
    int d0, lat;
    d0 = done_cnt;
    sb.push_back({1'b1, 24'hA55AC3});
    send(1'b1, 24'hA55AC3);
    vectors++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy: got busy=%b ready=%b, required 1 0", busy, cmd_ready);
    end
    wait_ready(lat);
    vectors++;
    if (lat != LATENCY) begin
      miscompares++;
      $display("FAIL single_latency: got %0d, required %0d", lat, LATENCY);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL single_done_count: got %0d, required 1", done_cnt - d0);
    end
    vectors++;
    if (spi_sclk !== 1'b1 || spi_mosi !== 1'b0 || spi_sync_n !== 2'b11) begin
      miscompares++;
      $display("FAIL single_post_idle: got sclk=%b mosi=%b sync=%b, required 1 0 11", spi_sclk, spi_mosi, spi_sync_n);
    end
  endtask

  task automatic test_back_to_back;
    int d0, lat;
    d0 = done_cnt;
    sb.push_back({1'b0, 24'h000001});
    sb.push_back({1'b0, 24'hFFFFFF});
    cmd_ch    = 1'b0;
    cmd_word  = 24'h000001;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_word = 24'hFFFFFF;
    wait_ready(lat);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready(lat);
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (last_gap != CG + 1) begin
      miscompares++;
      $display("FAIL b2b_sync_gap: got %0d, required %0d", last_gap, CG + 1);
    end
    vectors++;
    if (done_cnt - d0 != 2) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0);
    end
  endtask

  task automatic test_bad_channel;
    int n;
    @(negedge clk);
    valid3 = 1'b1;
    ch3    = 2'd3;
    word3  = 24'h123456;
    @(posedge clk);
    @(negedge clk);
    valid3 = 1'b0;
    vectors++;
    if (err3 !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_ch_err: got %b, required 1", err3);
    end
    vectors++;
    if (ready3 !== 1'b1 || sync3 !== 3'b111) begin
      miscompares++;
      $display("FAIL bad_ch_state: got ready=%b sync=%b, required 1 111", ready3, sync3);
    end
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if (err3_cnt != 1 || done3_cnt != 0 || sync3_low != 0) begin
      miscompares++;
      $display("FAIL bad_ch_pulses: got err=%0d done=%0d sync_low=%0d, required 1 0 0", err3_cnt, done3_cnt, sync3_low);
    end
    @(negedge clk);
    valid3 = 1'b1;
    ch3    = 2'd2;
    @(posedge clk);
    @(negedge clk);
    valid3 = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (sync3 !== 3'b011) begin
      miscompares++;
      $display("FAIL ch2_sync: got %b, required 011", sync3);
    end
    n = 0;
    while (!ready3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #1;
    vectors++;
    if (done3_cnt != 1 || err3_cnt != 1) begin
      miscompares++;
      $display("FAIL ch2_done: got done=%0d err=%0d, required 1 1", done3_cnt, err3_cnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    int n, d0, lat;
    send(1'b1, 24'hC3A5F0);
    n = 0;
    while (!(in_frame && falls == 10) && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n >= 1000) begin
      miscompares++;
      $display("FAIL midrst_wait: got falls=%0d, required 10", falls);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (spi_sync_n !== 2'b11 || spi_sclk !== 1'b1 || spi_mosi !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_pins: got sync=%b sclk=%b mosi=%b, required 11 1 0", spi_sync_n, spi_sclk, spi_mosi);
    end
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_ready: got ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    sb.push_back({1'b0, 24'h5A3C96});
    send(1'b0, 24'h5A3C96);
    wait_ready(lat);
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL midrst_refire_done: got %0d, required 1", done_cnt - d0);
    end
  endtask

`ifdef DAC_SPI_READBACK_EN
  task automatic test_readback;
    int r0, lat;
    r0 = rd_cnt;
    miso_pat = 24'h3C0FF0;
    sb.push_back({1'b1, 24'h0F0F0F});
    send(1'b1, 24'h0F0F0F);
    wait_ready(lat);
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (rd_seen !== 24'h3C0FF0) begin
      miscompares++;
      $display("FAIL readback_data: got %h, required 3c0ff0", rd_seen);
    end
    vectors++;
    if (rd_cnt - r0 != 1 || rd_coinc_bad) begin
      miscompares++;
      $display("FAIL readback_valid: got count=%0d misaligned=%0d, required 1 0", rd_cnt - r0, rd_coinc_bad);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got no summary by 500000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_channel();
    test_reset_mid_frame();
`ifdef DAC_SPI_READBACK_EN
    test_readback();
`endif
    repeat (5) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending frames, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
